// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and control types for the pipeline control slice.
package y86_pkg;

  localparam logic [3:0] SBUB    = 4'h0;
  localparam logic [3:0] AOK     = 4'h1;
  localparam logic [3:0] HLT     = 4'h2;
  localparam logic [3:0] ADR     = 4'h3;
  localparam logic [3:0] INS     = 4'h4;

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2,
    ST_HALT = 2'd3
  } ctrlState_t;

  // One bundle for every stage-register control plus the CC write enable.
  typedef struct packed {
    logic fStall;
    logic dStall;
    logic eStall;
    logic mStall;
    logic wStall;
    logic dBubble;
    logic eBubble;
    logic mBubble;
    logic setCc;
  } ctrlVec_t;

  // HLT, ADR and INS all stop the core; AOK and SBUB do not.
  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == HLT) || (stat == ADR) || (stat == INS);
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard detection and the free-running (RUN-mode) control vector.
module pipe_hazard
  import y86_pkg::*;
(
  input  logic [3:0] dIcode,
  input  logic [3:0] dSrcA,
  input  logic [3:0] dSrcB,
  input  logic [3:0] eIcode,
  input  logic [3:0] eDstM,
  input  logic       eCnd,
  input  logic [3:0] mIcode,
  input  logic [3:0] mStat,
  input  logic [3:0] wStat,
  output logic       loadUse,
  output logic       retHaz,
  output logic       mispred,
  output ctrlVec_t   runCtrl
);

  logic mExc;
  logic wExc;

  // Hazard terms and the control vector they imply when nothing else overrides it.
  always_comb begin
    loadUse = ((eIcode == IMRMOVQ) || (eIcode == IPOPQ)) && (eDstM != RNONE) &&
              ((eDstM == dSrcA) || (eDstM == dSrcB));
    retHaz  = (dIcode == IRET) || (eIcode == IRET) || (mIcode == IRET);
    mispred = (eIcode == IJXX) && !eCnd;
    mExc    = is_exc(mStat);
    wExc    = is_exc(wStat);

    runCtrl         = '0;
    runCtrl.fStall  = loadUse || retHaz;
    runCtrl.dStall  = loadUse;
    // A load-use stall holds D, so the ret bubble must wait until the load clears.
    runCtrl.dBubble = mispred || (retHaz && !loadUse);
    runCtrl.eBubble = mispred || loadUse;
    runCtrl.mBubble = mExc || wExc;
    runCtrl.wStall  = wExc;
    runCtrl.setCc   = (eIcode == IOPQ) && !mExc && !wExc;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: run-state FSM, stall/bubble gating, halt status latch and perf counters.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_INIT | first cycle after reset, flush D/E/M and hold F
//  ST_RUN  | normal execution, hazard-driven controls
//  ST_DBG  | frozen by debug; a step pulse releases exactly one cycle
//  ST_HALT | exception reached W; everything held until reset
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  input  logic             dbg_halt_req_i,
  input  logic             dbg_step_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             E_stall_o,
  output logic             M_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             set_cc_o,
  output logic [3:0]       cpu_stat_o,
  output logic             halted_o,
  output logic             dbg_halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  ctrlState_t state;
  ctrlState_t nextState;
  ctrlVec_t   runCtrl;
  ctrlVec_t   ctrl;
  logic       loadUse;
  logic       retHaz;
  logic       mispred;
  logic       stepNow;
  logic       advance;
  logic       wExc;

  pipe_hazard uHazard (
    .dIcode  (D_icode_i),
    .dSrcA   (d_srcA_i),
    .dSrcB   (d_srcB_i),
    .eIcode  (E_icode_i),
    .eDstM   (E_dstM_i),
    .eCnd    (e_Cnd_i),
    .mIcode  (M_icode_i),
    .mStat   (m_stat_i),
    .wStat   (W_stat_i),
    .loadUse (loadUse),
    .retHaz  (retHaz),
    .mispred (mispred),
    .runCtrl (runCtrl)
  );

  assign wExc    = is_exc(W_stat_i);
  assign stepNow = (state == ST_DBG) && dbg_step_i;
  assign advance = (state == ST_INIT) || (state == ST_RUN) || stepNow;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_INIT;
    else         state <= nextState;
  end

  // Next state: an exception beats a debug request; a step that retires an exception halts.
  always_comb begin
    nextState = state;
    unique case (state)
      ST_INIT: nextState = ST_RUN;
      ST_RUN: begin
        if (wExc)                nextState = ST_HALT;
        else if (dbg_halt_req_i) nextState = ST_DBG;
      end
      ST_DBG: begin
        if (stepNow && wExc)     nextState = ST_HALT;
        else if (!dbg_halt_req_i) nextState = ST_RUN;
      end
      ST_HALT: nextState = ST_HALT;
      default: nextState = ST_INIT;
    endcase
  end

  // Output gating: the hazard vector only reaches the stage regs on advance cycles.
  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_INIT: begin
        ctrl.fStall  = 1'b1;
        ctrl.dBubble = 1'b1;
        ctrl.eBubble = 1'b1;
        ctrl.mBubble = 1'b1;
      end
      ST_RUN: ctrl = runCtrl;
      ST_DBG: begin
        if (dbg_step_i) begin
          ctrl = runCtrl;
        end else begin
          ctrl.fStall = 1'b1;
          ctrl.dStall = 1'b1;
          ctrl.eStall = 1'b1;
          ctrl.mStall = 1'b1;
          ctrl.wStall = 1'b1;
        end
      end
      ST_HALT: begin
        ctrl.fStall = 1'b1;
        ctrl.dStall = 1'b1;
        ctrl.eStall = 1'b1;
        ctrl.mStall = 1'b1;
        ctrl.wStall = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign F_stall_o    = ctrl.fStall;
  assign D_stall_o    = ctrl.dStall;
  assign E_stall_o    = ctrl.eStall;
  assign M_stall_o    = ctrl.mStall;
  assign W_stall_o    = ctrl.wStall;
  assign D_bubble_o   = ctrl.dBubble;
  assign E_bubble_o   = ctrl.eBubble;
  assign M_bubble_o   = ctrl.mBubble;
  assign set_cc_o     = ctrl.setCc;
  assign halted_o     = (state == ST_HALT);
  assign dbg_halted_o = (state == ST_DBG);

  // Capture the offending W status on the single cycle that enters HALT.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                        cpu_stat_o <= AOK;
    else if ((nextState == ST_HALT) && (state != ST_HALT)) cpu_stat_o <= W_stat_i;
  end

  // Performance counters advance only when the pipeline actually moves.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cycle_cnt_o   <= '0;
      retired_cnt_o <= '0;
      stall_cnt_o   <= '0;
    end else if (advance) begin
      cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      if (W_stat_i == AOK)              retired_cnt_o <= retired_cnt_o + CNT_W'(1);
      if (loadUse || retHaz || mispred) stall_cnt_o   <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam logic [8:0] C_ZERO  = 9'h000;
  localparam logic [8:0] C_INIT  = 9'h10E;
  localparam logic [8:0] C_ALLST = 9'h1F0;
  localparam logic [8:0] C_LU    = 9'h184;
  localparam logic [8:0] C_MPRET = 9'h10C;
  localparam logic [8:0] C_RET   = 9'h108;
  localparam logic [8:0] C_SETCC = 9'h001;
  localparam logic [8:0] C_MEXC  = 9'h002;
  localparam logic [8:0] C_WEXC  = 9'h012;

  typedef struct {
    string      nm;
    logic [8:0] ctrl;
    logic [3:0] stat;
    logic       halted;
    logic       dbg;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  dIcode, dSrcA, dSrcB, eIcode, eDstM, mIcode, mStat, wStat;
  logic        eCnd, dbgReq, dbgStep;
  logic        fStall, dStall, eStall, mStall, wStall, dBub, eBub, mBub, setCc;
  logic [3:0]  cpuStat;
  logic        halted, dbgHalted;
  logic [31:0] cycleCnt, retiredCnt, stallCnt;
  logic [31:0] expCycle, expRetired, expStall;

  logic        wfS, wdS, weS, wmS, wwS, wdB, weB, wmB, wSc, wHalted, wDbg;
  logic [3:0]  wStatO, wCycle, wRetired, wStallC;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .D_icode_i(dIcode), .d_srcA_i(dSrcA), .d_srcB_i(dSrcB),
    .E_icode_i(eIcode), .E_dstM_i(eDstM), .e_Cnd_i(eCnd),
    .M_icode_i(mIcode), .m_stat_i(mStat), .W_stat_i(wStat),
    .dbg_halt_req_i(dbgReq), .dbg_step_i(dbgStep),
    .F_stall_o(fStall), .D_stall_o(dStall), .E_stall_o(eStall),
    .M_stall_o(mStall), .W_stall_o(wStall),
    .D_bubble_o(dBub), .E_bubble_o(eBub), .M_bubble_o(mBub),
    .set_cc_o(setCc), .cpu_stat_o(cpuStat), .halted_o(halted),
    .dbg_halted_o(dbgHalted), .cycle_cnt_o(cycleCnt),
    .retired_cnt_o(retiredCnt), .stall_cnt_o(stallCnt)
  );

  pipe_ctrl #(.CNT_W(4)) dutWrap (
    .clk_i(clk), .rstn_i(rstn),
    .D_icode_i(dIcode), .d_srcA_i(dSrcA), .d_srcB_i(dSrcB),
    .E_icode_i(eIcode), .E_dstM_i(eDstM), .e_Cnd_i(eCnd),
    .M_icode_i(mIcode), .m_stat_i(mStat), .W_stat_i(wStat),
    .dbg_halt_req_i(dbgReq), .dbg_step_i(dbgStep),
    .F_stall_o(wfS), .D_stall_o(wdS), .E_stall_o(weS),
    .M_stall_o(wmS), .W_stall_o(wwS),
    .D_bubble_o(wdB), .E_bubble_o(weB), .M_bubble_o(wmB),
    .set_cc_o(wSc), .cpu_stat_o(wStatO), .halted_o(wHalted),
    .dbg_halted_o(wDbg), .cycle_cnt_o(wCycle),
    .retired_cnt_o(wRetired), .stall_cnt_o(wStallC)
  );

  // Scoreboard consumer: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      logic [15:0] obs, req;
      e   = sbq.pop_front();
      obs = {fStall, dStall, eStall, mStall, wStall, dBub, eBub, mBub, setCc,
             cpuStat, halted, dbgHalted};
      req = {e.ctrl, e.stat, e.halted, e.dbg};
      tests++;
      if (obs !== req) begin
        fails++;
        $display("FAIL %s: got ctrl=%h stat=%h halted=%b dbg=%b, want ctrl=%h stat=%h halted=%b dbg=%b",
                 e.nm, obs[15:7], obs[6:3], obs[2], obs[1],
                 req[15:7], req[6:3], req[2], req[1]);
      end
    end
  end

  task automatic setIdle();
    dIcode = 4'h1; dSrcA = 4'hF; dSrcB = 4'hF;
    eIcode = 4'h1; eDstM = 4'hF; eCnd  = 1'b1;
    mIcode = 4'h1; mStat = 4'h1; wStat = 4'h1;
    dbgStep = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; covers exactly one clock cycle.
  task automatic cyc(input string nm, input logic [8:0] c, input logic [3:0] st,
                     input logic h, input logic d, input bit adv, input bit haz);
    exp_t e;
    e.nm = nm; e.ctrl = c; e.stat = st; e.halted = h; e.dbg = d;
    sbq.push_back(e);
    @(posedge clk);
    if (adv) begin
      expCycle++;
      if (wStat == 4'h1) expRetired++;
      if (haz) expStall++;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; dbgReq = 1'b0; setIdle();
    expCycle = '0; expRetired = '0; expStall = '0;
    cyc("in_reset", C_INIT, 4'h1, 1'b0, 1'b0, 0, 0);
    rstn = 1'b1;
    tests++;
    if ({cycleCnt, retiredCnt, stallCnt} !== 96'd0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, want 0/0/0", cycleCnt, retiredCnt, stallCnt);
    end
    cyc("init", C_INIT, 4'h1, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_hazards();
    logic [31:0] s0;
    cyc("run_idle", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    s0 = stallCnt;
    eIcode = 4'h5; eDstM = 4'h3; dSrcA = 4'h3;
    cyc("load_use_a", C_LU, 4'h1, 1'b0, 1'b0, 1, 1);
    tests++;
    if (stallCnt !== s0 + 32'd1) begin
      fails++;
      $display("FAIL stall_cnt_lu: got %0d, want %0d", stallCnt, s0 + 32'd1);
    end
    setIdle(); eIcode = 4'hB; eDstM = 4'h2; dSrcB = 4'h2;
    cyc("load_use_b", C_LU, 4'h1, 1'b0, 1'b0, 1, 1);
    setIdle(); eIcode = 4'h5; eDstM = 4'hF; dSrcA = 4'hF;
    cyc("lu_rnone", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    setIdle(); eIcode = 4'h6; eDstM = 4'h3; dSrcA = 4'h3;
    cyc("opq_setcc", C_SETCC, 4'h1, 1'b0, 1'b0, 1, 0);
    setIdle(); eIcode = 4'h7; eCnd = 1'b0; dIcode = 4'h9;
    cyc("mispred_ret", C_MPRET, 4'h1, 1'b0, 1'b0, 1, 1);
    setIdle(); mIcode = 4'h9;
    cyc("ret_in_m", C_RET, 4'h1, 1'b0, 1'b0, 1, 1);
    setIdle(); eIcode = 4'h5; eDstM = 4'h3; dSrcA = 4'h3; dIcode = 4'h9;
    cyc("lu_and_ret", C_LU, 4'h1, 1'b0, 1'b0, 1, 1);
    setIdle(); eIcode = 4'h6; mStat = 4'h3;
    cyc("setcc_gated", C_MEXC, 4'h1, 1'b0, 1'b0, 1, 0);
    setIdle();
    cyc("run_idle2", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    tests++;
    if ({cycleCnt, retiredCnt, stallCnt} !== {expCycle, expRetired, expStall}) begin
      fails++;
      $display("FAIL run_counters: got %0d/%0d/%0d, want %0d/%0d/%0d",
               cycleCnt, retiredCnt, stallCnt, expCycle, expRetired, expStall);
    end
  endtask

  task automatic test_halt();
    wStat = 4'h3;
    cyc("w_exc", C_WEXC, 4'h1, 1'b0, 1'b0, 1, 0);
    wStat = 4'h1;
    cyc("halted", C_ALLST, 4'h3, 1'b1, 1'b0, 0, 0);
    dbgReq = 1'b1; dbgStep = 1'b1;
    cyc("halt_ignores_dbg", C_ALLST, 4'h3, 1'b1, 1'b0, 0, 0);
    cyc("halt_sticky", C_ALLST, 4'h3, 1'b1, 1'b0, 0, 0);
    tests++;
    if ({cycleCnt, retiredCnt, stallCnt} !== {expCycle, expRetired, expStall}) begin
      fails++;
      $display("FAIL halt_frozen: got %0d/%0d/%0d, want %0d/%0d/%0d",
               cycleCnt, retiredCnt, stallCnt, expCycle, expRetired, expStall);
    end
  endtask

  task automatic test_debug();
    logic [31:0] c0;
    cyc("run_pre_dbg", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    dbgReq = 1'b1;
    cyc("dbg_req", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    cyc("dbg_frozen", C_ALLST, 4'h1, 1'b0, 1'b1, 0, 0);
    c0 = cycleCnt;
    for (int i = 0; i < 3; i++) begin
      dbgStep = 1'b1;
      if (i == 1) begin
        eIcode = 4'h5; eDstM = 4'h3; dSrcA = 4'h3;
        cyc("dbg_step_lu", C_LU, 4'h1, 1'b0, 1'b1, 1, 1);
      end else begin
        cyc("dbg_step", C_ZERO, 4'h1, 1'b0, 1'b1, 1, 0);
      end
      setIdle();
      cyc("dbg_gap", C_ALLST, 4'h1, 1'b0, 1'b1, 0, 0);
    end
    tests++;
    if (cycleCnt !== c0 + 32'd3 || stallCnt !== expStall) begin
      fails++;
      $display("FAIL dbg_step_counts: got cycle=%0d stall=%0d, want cycle=%0d stall=%0d",
               cycleCnt, stallCnt, c0 + 32'd3, expStall);
    end
    dbgReq = 1'b0;
    cyc("dbg_release", C_ALLST, 4'h1, 1'b0, 1'b1, 0, 0);
    cyc("dbg_back_run", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    dbgReq = 1'b1;
    cyc("dbg_req2", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    cyc("dbg_frozen2", C_ALLST, 4'h1, 1'b0, 1'b1, 0, 0);
    dbgReq = 1'b0; dbgStep = 1'b1; eIcode = 4'h6;
    cyc("step_and_release", C_SETCC, 4'h1, 1'b0, 1'b1, 1, 0);
    setIdle();
    cyc("after_step_release", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_step_halt();
    dbgReq = 1'b1;
    cyc("sh_req", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    cyc("sh_frozen", C_ALLST, 4'h1, 1'b0, 1'b1, 0, 0);
    dbgStep = 1'b1; wStat = 4'h4;
    cyc("sh_step_exc", C_WEXC, 4'h1, 1'b0, 1'b1, 1, 0);
    setIdle();
    cyc("sh_halted", C_ALLST, 4'h4, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 14; i++) cyc("wrap_run", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    tests++;
    if (wCycle !== 4'hF) begin
      fails++;
      $display("FAIL wrap_max: got %h, want f", wCycle);
    end
    cyc("wrap_run", C_ZERO, 4'h1, 1'b0, 1'b0, 1, 0);
    tests++;
    if (wCycle !== 4'h0 || cycleCnt !== 32'd16) begin
      fails++;
      $display("FAIL wrap_zero: got narrow=%h wide=%0d, want 0 and 16", wCycle, cycleCnt);
    end
  endtask

  initial begin
    rstn = 1'b0; dbgReq = 1'b0; setIdle();
    expCycle = '0; expRetired = '0; expStall = '0;
    @(posedge clk); #1;
    test_reset();
    test_hazards();
    test_halt();
    test_reset();
    tests++;
    if (cpuStat !== 4'h1 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_from_halt: got stat=%h halted=%b, want 1 and 0", cpuStat, halted);
    end
    test_debug();
    test_step_halt();
    test_reset();
    test_wrap();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
